// File: rtl/note_pkg.sv
// Shared state encoding and tempo arithmetic for the note sequencer.
package note_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRecord = 2'd1,
    StPlay   = 2'd2
  } seq_state_e;

  function automatic int unsigned bpm_of(input logic [2:0] sel);
    int unsigned bpm;
    case (sel)
      3'd0:    bpm = 40;
      3'd1:    bpm = 60;
      3'd2:    bpm = 80;
      3'd3:    bpm = 100;
      3'd4:    bpm = 120;
      3'd5:    bpm = 140;
      3'd6:    bpm = 180;
      default: bpm = 220;
    endcase
    return bpm;
  endfunction

  function automatic int unsigned note_width(input int unsigned num_strings,
                                             input int unsigned num_frets);
    return num_strings * (num_frets + 1);
  endfunction

  // Cycles per beat, truncated; 64-bit intermediate keeps CLK_HZ*60 from overflowing.
  function automatic int unsigned beat_period(input int unsigned clk_hz, input logic [2:0] sel);
    logic [63:0] per_min;
    per_min = 64'(clk_hz) * 64'd60;
    return 32'(per_min / 64'(bpm_of(sel)));
  endfunction

endpackage

// File: rtl/beat_timer.sv
// Down-counting beat timer: one tick per beat period and a capture window that
// closes GUARD_CYCLES before each tick.
module beat_timer
  import note_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned GUARD_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [2:0] tempo_sel,
  input  logic       restart,
  output logic       beat_tick,
  output logic       window
);

  localparam int unsigned MaxPeriod = beat_period(CLK_HZ, 3'd0);
  localparam int unsigned CntW      = $clog2(MaxPeriod + 1);

  logic [CntW-1:0] reload_tab [8];
  logic [CntW-1:0] reload;
  logic [CntW-1:0] cnt_q;

  // Constant per-tempo reload values, so no divider is built.
  for (genvar i = 0; i < 8; i++) begin : g_reload
    assign reload_tab[i] = CntW'(beat_period(CLK_HZ, 3'(i)) - 1);
  end

  assign reload = reload_tab[tempo_sel];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= reload;
    end else if (restart || cnt_q == '0) begin
      cnt_q <= reload;
    end else begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign beat_tick = (cnt_q == '0);
  assign window    = (cnt_q > CntW'(GUARD_CYCLES));

endmodule

// File: rtl/note_sequencer.sv
// Beat-synchronous fretboard recorder: captures one string x fret note word per beat
// into a small RAM and plays the take back, optionally looping.
module note_sequencer
  import note_pkg::*;
#(
  parameter int unsigned  NUM_STRINGS  = 6,
  parameter int unsigned  NUM_FRETS    = 4,
  parameter int unsigned  DEPTH        = 64,
  parameter int unsigned  CLK_HZ       = 50_000_000,
  parameter int unsigned  GUARD_CYCLES = 1000,
  localparam int unsigned NOTE_W       = note_width(NUM_STRINGS, NUM_FRETS),
  localparam int unsigned AW           = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [2:0]             tempo_sel,
  input  logic [NUM_STRINGS-1:0] strings,
  input  logic [NUM_FRETS-1:0]   frets,
  input  logic                   cmd_record,
  input  logic                   cmd_play,
  input  logic                   cmd_stop,
  input  logic                   loop_en,
  output logic [NOTE_W-1:0]      note_out,
  output logic                   note_valid,
  output logic                   beat_tick,
  output logic [AW-1:0]          address,
  output logic [AW:0]            length,
  output logic                   full,
  output logic [1:0]             state
);

  localparam int unsigned FW = $clog2(NUM_FRETS + 1);
  localparam int unsigned LW = AW + 1;

  seq_state_e             state_q;
  logic [NOTE_W-1:0]      mem [DEPTH];
  logic [NOTE_W-1:0]      note_q;
  logic [NOTE_W-1:0]      note_enc;
  logic                   note_valid_q;
  logic                   full_q;
  logic [AW-1:0]          addr_q;
  logic [LW-1:0]          len_q;
  logic [NUM_STRINGS-1:0] acc_s_q;
  logic [FW-1:0]          acc_f_q;
  logic [FW-1:0]          fret_pos;
  logic                   window;
  logic                   go_record;
  logic                   go_play;
  logic                   restart;
  logic                   mem_we;

  beat_timer #(
    .CLK_HZ      (CLK_HZ),
    .GUARD_CYCLES(GUARD_CYCLES)
  ) u_beat_timer (
    .clk      (clk),
    .resetn   (resetn),
    .tempo_sel(tempo_sel),
    .restart  (restart),
    .beat_tick(beat_tick),
    .window   (window)
  );

  // Stop outranks record, which outranks play.
  assign go_record = (state_q == StIdle) && !cmd_stop && cmd_record;
  assign go_play   = (state_q == StIdle) && !cmd_stop && !cmd_record && cmd_play && (len_q != '0);
  assign restart   = go_record || go_play;
  assign mem_we    = (state_q == StRecord) && beat_tick && !cmd_stop;

  always_comb begin
    fret_pos = '0;
    for (int unsigned i = 0; i < NUM_FRETS; i++) begin
      if (frets[i]) fret_pos = FW'(i + 1);
    end
  end

  always_comb begin
    note_enc = '0;
    for (int unsigned f = 0; f < NUM_FRETS + 1; f++) begin
      if (acc_f_q == FW'(f)) note_enc[f*NUM_STRINGS +: NUM_STRINGS] = acc_s_q;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[addr_q] <= note_enc;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      note_q       <= '0;
      note_valid_q <= 1'b0;
      addr_q       <= '0;
      len_q        <= '0;
      full_q       <= 1'b0;
      acc_s_q      <= '0;
      acc_f_q      <= '0;
    end else begin
      note_valid_q <= 1'b0;

      if (restart || beat_tick) begin
        acc_s_q <= '0;
        acc_f_q <= '0;
      end else if (window) begin
        acc_s_q <= acc_s_q | strings;
        if (fret_pos > acc_f_q) acc_f_q <= fret_pos;
      end

      if (cmd_stop) begin
        state_q <= StIdle;
        note_q  <= '0;
      end else begin
        case (state_q)
          StIdle: begin
            note_q <= '0;
            if (go_record) begin
              state_q <= StRecord;
              addr_q  <= '0;
              len_q   <= '0;
              full_q  <= 1'b0;
            end else if (go_play) begin
              state_q <= StPlay;
              addr_q  <= '0;
            end
          end
          StRecord: begin
            if (beat_tick) begin
              note_q       <= note_enc;
              note_valid_q <= 1'b1;
              addr_q       <= addr_q + 1'b1;
              len_q        <= len_q + 1'b1;
              if (len_q == LW'(DEPTH - 1)) begin
                full_q  <= 1'b1;
                state_q <= StIdle;
              end
            end
          end
          StPlay: begin
            if (beat_tick) begin
              note_q       <= mem[addr_q];
              note_valid_q <= 1'b1;
              if ({1'b0, addr_q} == len_q - 1'b1) begin
                if (loop_en) addr_q <= '0;
                else         state_q <= StIdle;
              end else begin
                addr_q <= addr_q + 1'b1;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign note_out   = note_q;
  assign note_valid = note_valid_q;
  assign address    = addr_q;
  assign length     = len_q;
  assign full       = full_q;
  assign state      = state_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Randomized scoreboard bench for note_sequencer at CLK_HZ=400, GUARD=10, DEPTH=4.
module tb_note_sequencer;

  localparam int NS    = 6;
  localparam int NF    = 4;
  localparam int DEPTH = 4;
  localparam int GUARD = 10;
  localparam int P     = 200;
  localparam int NW    = NS * (NF + 1);

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [2:0]    tempo_sel = 3'd4;
  logic [NS-1:0] strings = '0;
  logic [NF-1:0] frets = '0;
  logic          cmd_record = 1'b0;
  logic          cmd_play = 1'b0;
  logic          cmd_stop = 1'b0;
  logic          loop_en = 1'b0;
  logic [NW-1:0] note_out;
  logic          note_valid;
  logic          beat_tick;
  logic [1:0]    address;
  logic [2:0]    length;
  logic          full;
  logic [1:0]    state;

  int            checks = 0;
  int            errors = 0;
  logic [NW-1:0] exp_q[$];
  logic [NW-1:0] take [DEPTH];
  logic          prev_tick = 1'b0;

  note_sequencer #(
    .NUM_STRINGS (NS),
    .NUM_FRETS   (NF),
    .DEPTH       (DEPTH),
    .CLK_HZ      (400),
    .GUARD_CYCLES(GUARD)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .tempo_sel (tempo_sel),
    .strings   (strings),
    .frets     (frets),
    .cmd_record(cmd_record),
    .cmd_play  (cmd_play),
    .cmd_stop  (cmd_stop),
    .loop_en   (loop_en),
    .note_out  (note_out),
    .note_valid(note_valid),
    .beat_tick (beat_tick),
    .address   (address),
    .length    (length),
    .full      (full),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int top_fret(input logic [NF-1:0] f);
    int r = 0;
    for (int i = 0; i < NF; i++) if (f[i]) r = i + 1;
    return r;
  endfunction

  task automatic pulse(input bit rec, input bit play, input bit stop);
    cmd_record = rec;
    cmd_play   = play;
    cmd_stop   = stop;
    step();
    cmd_record = 1'b0;
    cmd_play   = 1'b0;
    cmd_stop   = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, 64'(state), 64'd0);
    check({tag, "_note_out"}, 64'(note_out), 64'd0);
    check({tag, "_note_valid"}, 64'(note_valid), 64'd0);
    check({tag, "_beat_tick"}, 64'(beat_tick), 64'd0);
    check({tag, "_address"}, 64'(address), 64'd0);
    check({tag, "_length"}, 64'(length), 64'd0);
    check({tag, "_full"}, 64'(full), 64'd0);
  endtask

  // One beat, starting just after the edge that restarted or last ticked the timer.
  // mode 0: sparse random strikes, 1: strings[2] with frets 0011 early, 2: strings[0] late only.
  task automatic run_beat(input int mode, input bit play, input int idx, input bit stop_at_tick);
    logic [NS-1:0] s;
    logic [NF-1:0] f;
    logic [NS-1:0] acc_s;
    int            acc_f;
    logic [NW-1:0] word;
    acc_s = '0;
    acc_f = 0;
    for (int j = 1; j <= P; j++) begin
      s = '0;
      f = '0;
      case (mode)
        0: if ($urandom_range(0, 15) == 0) begin
             s = NS'($urandom);
             f = NF'($urandom);
           end
        1: if (j >= 50 && j < 60) begin
             s = 6'b000100;
             f = 4'b0011;
           end
        default: if (j >= P - GUARD) s = 6'b000001;
      endcase
      strings = s;
      frets   = f;
      // The counter reads P-j before edge j; only counts above GUARD capture.
      if (P - j > GUARD) begin
        acc_s |= s;
        if (top_fret(f) > acc_f) acc_f = top_fret(f);
      end
      if (j == P) begin
        check("beat_tick_at_period", 64'(beat_tick), 64'd1);
        word = play ? take[idx] : NW'(acc_s) << (acc_f * NS);
        if (!play) take[idx] = word;
        if (stop_at_tick) cmd_stop = 1'b1;
        else exp_q.push_back(word);
      end
      step();
    end
    strings  = '0;
    frets    = '0;
    cmd_stop = 1'b0;
  endtask

  initial begin : monitor
    logic [NW-1:0] w;
    forever begin
      @(negedge clk);
      if (note_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_note got=%h want=none", note_out);
        end else begin
          w = exp_q.pop_front();
          if (note_out !== w) begin
            errors++;
            $display("FAIL note_word got=%h want=%h", note_out, w);
          end
        end
        checks++;
        if (prev_tick !== 1'b1) begin
          errors++;
          $display("FAIL note_latency prev_beat_tick got=%b want=1", prev_tick);
        end
      end
      prev_tick = beat_tick;
    end
  end

  initial begin : stimulus
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    resetn = 1'b1;

    // Idle metronome: ticks at cycles 199 and 399 after reset.
    for (int n = 1; n <= 450; n++) begin
      step();
      check("idle_beat_tick", 64'(beat_tick), 64'((n % P) == P - 1));
    end
    check("idle_note_out", 64'(note_out), 64'd0);
    check("idle_state", 64'(state), 64'd0);

    // Record a full take.
    pulse(1'b1, 1'b0, 1'b0);
    check("rec_state", 64'(state), 64'd1);
    check("rec_len_start", 64'(length), 64'd0);
    run_beat(1, 1'b0, 0, 1'b0);
    check("rec_first_valid", 64'(note_valid), 64'd1);
    check("rec_first_word", 64'(note_out), 64'd1 << 14);
    check("rec_len_one", 64'(length), 64'd1);
    run_beat(0, 1'b0, 1, 1'b0);
    run_beat(2, 1'b0, 2, 1'b0);
    run_beat(0, 1'b0, 3, 1'b0);
    check("rec_full", 64'(full), 64'd1);
    check("rec_done_state", 64'(state), 64'd0);
    check("rec_len_depth", 64'(length), 64'd4);
    for (int n = 0; n < P + 20; n++) begin
      strings = NS'($urandom);
      step();
    end
    strings = '0;
    check("post_full_len", 64'(length), 64'd4);
    check("post_full_state", 64'(state), 64'd0);

    // Playback without looping.
    loop_en = 1'b0;
    pulse(1'b0, 1'b1, 1'b0);
    check("play_state", 64'(state), 64'd2);
    check("play_addr_start", 64'(address), 64'd0);
    for (int i = 0; i < DEPTH; i++) run_beat(0, 1'b1, i, 1'b0);
    check("play_end_state", 64'(state), 64'd0);
    check("play_end_addr", 64'(address), 64'd3);
    check("play_end_len", 64'(length), 64'd4);
    repeat (2) step();
    check("play_end_note_zero", 64'(note_out), 64'd0);

    // Looping playback: fifth output repeats the first, then a stop on a tick.
    loop_en = 1'b1;
    pulse(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) run_beat(0, 1'b1, i % DEPTH, 1'b0);
    check("loop_state", 64'(state), 64'd2);
    check("loop_addr", 64'(address), 64'd1);
    run_beat(0, 1'b1, 1, 1'b1);
    check("stop_tick_state", 64'(state), 64'd0);
    check("stop_tick_addr", 64'(address), 64'd1);
    check("stop_tick_valid", 64'(note_valid), 64'd0);
    check("stop_tick_len", 64'(length), 64'd4);
    loop_en = 1'b0;

    // Asynchronous reset in the middle of playback.
    pulse(1'b0, 1'b1, 1'b0);
    run_beat(0, 1'b1, 0, 1'b0);
    repeat (50) step();
    check("midplay_state", 64'(state), 64'd2);
    #2;
    resetn = 1'b0;
    #1;
    check_reset_values("async_reset");
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    step();

    // Commands that must be ignored in IDLE.
    pulse(1'b0, 1'b1, 1'b0);
    repeat (3) step();
    check("play_empty_state", 64'(state), 64'd0);
    pulse(1'b1, 1'b0, 1'b1);
    repeat (3) step();
    check("rec_stop_state", 64'(state), 64'd0);
    check("rec_stop_len", 64'(length), 64'd0);

    repeat (5) step();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/note_sequencer.md
# note_sequencer

Parametrised successor to the stage-1 guitar recorder datapath. It samples the fretboard GPIO (string and fret-bar contacts) inside a tempo-driven beat window and encodes each beat as a one-hot string×fret note word. The word is stored in an internal memory. The block plays the memory back beat by beat, with optional looping, to the audio/HEX stage. It sits between the board I/O and the audio/display back end, and replaces the separate control/datapath/clock-divider split with one self-timed block.

## Interface
- NUM_STRINGS, 6, number of string contacts
- NUM_FRETS, 4, number of fret bars; fret positions = NUM_FRETS+1 (position 0 = open)
- DEPTH, 64, note memory entries; AW = clog2(DEPTH)
- CLK_HZ, 50_000_000, clock frequency used to derive beat periods
- GUARD_CYCLES, 1000, cycles at the end of each beat during which input is not captured
- NOTE_W is derived as NUM_STRINGS*(NUM_FRETS+1); it is not an override parameter
- clk  in  1  system clock
- resetn  in  1  asynchronous, active-low reset
- tempo_sel  in  3  selects 40/60/80/100/120/140/180/220 notes/min
- strings  in  NUM_STRINGS  string contacts, high = struck
- frets  in  NUM_FRETS  fret bars, bit i = bar i+1 pressed
- cmd_record, cmd_play, cmd_stop  in  1 each  single-cycle command pulses
- loop_en  in  1  wrap playback to entry 0 at end of take
- note_out  out  NOTE_W  current note word
- note_valid  out  1  one-cycle pulse when note_out updates
- beat_tick  out  1  one-cycle pulse per beat
- address  out  AW  current memory pointer
- length  out  AW+1  number of recorded notes
- full  out  1  last take hit DEPTH
- state  out  2  0 IDLE, 1 RECORD, 2 PLAY

## Operation
- Beat period P = (CLK_HZ*60)/bpm, truncated. The beat counter loads P-1 and counts down; beat_tick is asserted when the counter is 0, then it reloads. tempo_sel is sampled only at reload.
- The capture window is open while the counter > GUARD_CYCLES. During the window, acc_s |= strings and acc_f = max(acc_f, highest pressed fret position). Both accumulators clear on beat_tick.
- Encoding: bit (acc_f*NUM_STRINGS + s) = acc_s[s]. All other bits are 0.
- IDLE:
  - cmd_record → RECORD; address=0, length=0, full=0.
  - cmd_play with length>0 → PLAY; address=0.
  - cmd_play with length=0 is ignored.
- Priority when commands coincide: stop > record > play. cmd_record and cmd_play are ignored outside IDLE.
- Entering RECORD or PLAY reloads the counter to P-1 and clears the accumulators.
- RECORD, on each beat_tick:
  - Write the encoded note to mem[address], then address++ and length++.
  - Echo the note on note_out with note_valid.
  - If length reaches DEPTH: full=1, go to IDLE.
- PLAY, on each beat_tick:
  - Output mem[address], then address++.
  - At address = length-1: if loop_en, address wraps to 0; otherwise go to IDLE after emitting that note.
- cmd_stop in any state → IDLE. length is kept and address is frozen. A partial beat is discarded.
- In IDLE, note_out = 0 and the counter keeps running, so beat_tick stays live for the metronome LED.

## Timing
- Reset values: state=IDLE, note_out=0, note_valid=0, beat_tick=0, address=0, length=0, full=0, counter=P(tempo_sel)-1, accumulators and memory pointer zeroed. Memory contents are undefined.
- Latency: note_out and note_valid appear exactly 1 cycle after beat_tick in both RECORD and PLAY. The memory read is synchronous.
- A command takes effect on the clock edge after the pulse; state changes 1 cycle after the command cycle.
- A cmd_stop coinciding with beat_tick wins: no write and no output that beat.
- Asynchronous reset mid-take returns to IDLE immediately and length becomes 0.

## Structure
- Shared package note_pkg: the state encoding, the bpm table (40…220), and the function computing NOTE_W and P.
- Sub-module beat_timer (parameters CLK_HZ, GUARD_CYCLES): provides beat_tick, window, and a restart input.
- Memory is an inferred DEPTH×NOTE_W synchronous RAM inside note_sequencer.

## Test plan
All scenarios use CLK_HZ=400, GUARD_CYCLES=10, DEPTH=4, defaults otherwise; tempo_sel=4 gives P=200.
- Reset, then idle for 450 cycles → beat_tick pulses at cycles 199 and 399 after reset; note_out=0; state=0.
- cmd_record; in beat 1 strike strings[2] with frets=4'b0011 → first note word has only bit 2*6+2=14 set; note_valid 1 cycle after beat_tick; length=1.
- Record 4 beats → full=1, state=IDLE, length=4. A fifth beat_tick produces no write.
- cmd_play with loop_en=0 → the 4 recorded words emerge in order on successive beats, then state=IDLE and address=3. Repeat with loop_en=1 → the fifth output equals the first.
- cmd_play with length=0 → state stays IDLE. Same-cycle cmd_record+cmd_stop in IDLE → stays IDLE.
- Strike strings[0] only during the last 10 cycles of a beat → stored note is 0. Assert resetn low mid-PLAY → all outputs return to reset values asynchronously.
